spi_ram_arbiter: RTL

- Shares the single 16-bit-word SPI RAM controller between two requesters: port 0 (debug/loader) and port 1 (CPU core).
- Sits between the requesters and the controller's addr/data/start_read/start_write/busy interface.
- Serialises accesses, generates one-cycle start pulses and absorbs the controller's one-cycle busy-rise latency.
- Returns read data with a done pulse and guards against a hung controller with a watchdog.

---
 rtl/spi_ram_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_ram_arbiter.sv
// Two-port arbiter in front of the single-word SPI RAM controller.
// Optional `SPI_ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed priority.
`timescale 1ns/1ps

module spi_ram_arbiter #(
   parameter int unsigned ADDR_BITS      = 16,
   parameter int unsigned DATA_BITS      = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic                 clk,
   input  logic                 rst_n,

   input  logic                 req0_valid,
   input  logic                 req0_we,
   input  logic [ADDR_BITS-1:0] req0_addr,
   input  logic [DATA_BITS-1:0] req0_wdata,
   output logic                 req0_done,
   output logic [DATA_BITS-1:0] req0_rdata,

   input  logic                 req1_valid,
   input  logic                 req1_we,
   input  logic [ADDR_BITS-1:0] req1_addr,
   input  logic [DATA_BITS-1:0] req1_wdata,
   output logic                 req1_done,
   output logic [DATA_BITS-1:0] req1_rdata,

   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [DATA_BITS-1:0] mem_wdata,
   output logic                 mem_start_read,
   output logic                 mem_start_write,
   input  logic [DATA_BITS-1:0] mem_rdata,
   input  logic                 mem_busy,

   output logic [1:0]           grant,
   output logic                 timeout_err
);

   localparam int unsigned CNT_BITS = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_SETTLE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t                state;
   state_t                state_nxt;

   logic                  win;
   logic                  we_q;
   logic [CNT_BITS-1:0]   wd_cnt;
   logic                  wd_expire;

   logic                  any_valid;
   logic                  sel;
   logic                  sel_we;
   logic [ADDR_BITS-1:0]  sel_addr;
   logic [DATA_BITS-1:0]  sel_wdata;

`ifdef SPI_ARB_ROUND_ROBIN_EN
   logic                  last_served;
`endif

   assign any_valid = req0_valid | req1_valid;

   // Winner selection; a lone requester always wins.
   always_comb begin
      sel = 1'b0;
`ifdef SPI_ARB_ROUND_ROBIN_EN
      if (req0_valid && req1_valid) begin
         sel = ~last_served;
      end else begin
         sel = ~req0_valid;
      end
`else
      sel = ~req0_valid;
`endif
      sel_we    = sel ? req1_we    : req0_we;
      sel_addr  = sel ? req1_addr  : req0_addr;
      sel_wdata = sel ? req1_wdata : req0_wdata;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; the watchdog fires on the TIMEOUT_CYCLES-th busy WAIT cycle.
   always_comb begin
      state_nxt = state;
      wd_expire = 1'b0;
      case (state)
         S_IDLE: begin
            if (any_valid) begin
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE:  state_nxt = S_SETTLE;
         S_SETTLE: state_nxt = S_WAIT;
         S_WAIT: begin
            if (!mem_busy) begin
               state_nxt = S_DONE;
            end else if (wd_cnt == CNT_BITS'(TIMEOUT_CYCLES - 1)) begin
               state_nxt = S_DONE;
               wd_expire = 1'b1;
            end
         end
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Request latch, memory-side outputs and grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win             <= 1'b0;
         we_q            <= 1'b0;
         mem_addr        <= '0;
         mem_wdata       <= '0;
         mem_start_read  <= 1'b0;
         mem_start_write <= 1'b0;
         grant           <= 2'b00;
      end else begin
         mem_start_read  <= 1'b0;
         mem_start_write <= 1'b0;
         if (state == S_IDLE && any_valid) begin
            win             <= sel;
            we_q            <= sel_we;
            mem_addr        <= sel_addr;
            mem_wdata       <= sel_wdata;
            mem_start_read  <= ~sel_we;
            mem_start_write <= sel_we;
            grant           <= sel ? 2'b10 : 2'b01;
         end else if (state == S_DONE) begin
            mem_addr        <= '0;
            mem_wdata       <= '0;
            grant           <= 2'b00;
         end
      end
   end

   // Watchdog counter, cleared on entry to WAIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt <= '0;
      end else if (state == S_SETTLE) begin
         wd_cnt <= '0;
      end else if (state == S_WAIT && mem_busy) begin
         wd_cnt <= wd_cnt + CNT_BITS'(1);
      end
   end

   // Completion pulses, read data return and sticky timeout flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req0_done   <= 1'b0;
         req1_done   <= 1'b0;
         req0_rdata  <= '0;
         req1_rdata  <= '0;
         timeout_err <= 1'b0;
      end else begin
         req0_done <= (state == S_WAIT) && (state_nxt == S_DONE) && !win;
         req1_done <= (state == S_WAIT) && (state_nxt == S_DONE) &&  win;
         if (state == S_WAIT && state_nxt == S_DONE) begin
            if (wd_expire) begin
               timeout_err <= 1'b1;
               if (win) begin
                  req1_rdata <= '0;
               end else begin
                  req0_rdata <= '0;
               end
            end else if (!we_q) begin
               if (win) begin
                  req1_rdata <= mem_rdata;
               end else begin
                  req0_rdata <= mem_rdata;
               end
            end
         end
      end
   end

`ifdef SPI_ARB_ROUND_ROBIN_EN
   // Last-served pointer; reset value 1 hands port 0 the first contention.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_served <= 1'b1;
      end else if (state == S_DONE) begin
         last_served <= win;
      end
   end
`endif

endmodule
